seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller that shares one hex-to-seven-segment decoder across NUM_DIGITS common-anode digits. It accepts a packed display word over a valid/ready handshake, double-buffers it so updates only take effect at frame boundaries, and applies per-digit blanking and optional leading-zero suppression. It walks the digits with a guard (all-off) interval between slots to prevent ghosting. It sits between the application logic and the board's segment/anode pins; the shared decoder's output is fed back in on `seg_in`.

---
 rtl/seven_seg_scan_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seven_seg_scan_ctrl
// Brief  : Multiplexed seven-segment scan controller with a double-buffered
//          display word, per-digit blanking and leading-zero suppression.
// Rev    : 1.0
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int SHOW_CYC   = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [3:0]              dec_bin,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int c_MAX_CYC = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
  localparam int c_IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(SHOW_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYC - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_xfer;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic [NUM_DIGITS-1:0]   w_an_lit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_slot_end  = 1'b0;
    case (r_state)
      ST_GUARD: begin
        if (r_cnt == c_GUARD_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == c_SHOW_LAST) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = '0;
          w_slot_end  = 1'b1;
          w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_GUARD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_boundary = w_slot_end && (r_idx == c_IDX_LAST);
  assign w_xfer     = load_valid && load_ready;

  // Commit and accept are mutually exclusive: ready is low while pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active   <= '0;
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      load_ready <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_active   <= r_shadow;
      r_pending  <= 1'b0;
      load_ready <= 1'b1;
    end else if (w_xfer) begin
      r_shadow   <= load_data;
      r_pending  <= 1'b1;
      load_ready <= 1'b0;
    end
  end

  // w_zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic w_acc;
    w_acc       = 1'b1;
    w_zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_acc          = w_acc && (r_active[4*i +: 4] == 4'h0);
      w_zero_from[i] = w_acc;
    end
  end

  assign dec_bin  = r_active[4*r_idx +: 4];
  assign w_dark   = blank_mask[r_idx] || (lz_en && (r_idx != '0) && w_zero_from[r_idx]);
  assign w_an_lit = ~(NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n    <= '1;
      seg_out <= 7'h7F;
    end else if ((r_state == ST_SHOW) && !w_dark) begin
      an_n    <= w_an_lit;
      seg_out <= seg_in;
    end else begin
      an_n    <= '1;
      seg_out <= 7'h7F;
    end
  end

endmodule
`default_nettype wire
